// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the serial chunk adder:
//   state_e    - FSM state encoding (IDLE / RUN / DONE)
//   cnt_width  - width of the chunk counter for a given chunk count
// ---------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A counter for n chunks needs clog2(n) bits. It always has at least one
   // bit, so that a single-chunk configuration still has a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple adder built from fulladder cells.
//   a, b   : CHUNK-bit operands
//   c_in   : carry into bit 0
//   s      : CHUNK-bit sum
//   c_out  : carry out of bit CHUNK-1
//   c_msb  : carry into bit CHUNK-1 (XOR with c_out gives signed overflow)
// ---------------------------------------------------------------------------
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] s,
   output logic             c_out,
   output logic             c_msb
);

   // c[i] is the carry into bit i; c[CHUNK] is the carry out of the chunk.
   logic [CHUNK:0] c;

   assign c[0] = c_in;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      fulladder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign c_out = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/fulladder.sv
// ---------------------------------------------------------------------------
// fulladder
// Single-bit full adder cell.
//   a, b, ci : input  bits
//   s        : sum bit
//   co       : carry out
// ---------------------------------------------------------------------------
module fulladder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_chunk_adder.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
// least-significant chunk first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled when not busy (IDLE or DONE)
//   sub        : 0 -> a+b+ci, 1 -> a-b (ci ignored)
//   ci         : carry-in for add mode
//   a, b       : operands, captured on an accepted start
//   busy       : high while chunks are being processed
//   done       : one-cycle pulse, result valid
//   sum        : result, held from done until the next accepted start
//   co         : carry out of the MSB (for sub: 1 = no borrow)
//   ovf        : signed overflow
// ---------------------------------------------------------------------------
module serial_chunk_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             ci,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] ch_s;
   logic             ch_cout;
   logic             ch_cmsb;

   // The operand registers shift right each RUN cycle, so the current chunk
   // is always in the low CHUNK bits.
   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_q[CHUNK-1:0]),
      .b     (b_q[CHUNK-1:0]),
      .c_in  (carry_q),
      .s     (ch_s),
      .c_out (ch_cout),
      .c_msb (ch_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            // New chunk enters at the top; after N cycles the first chunk
            // has reached bit 0 and the result is in place.
            sum_d   = (sum_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
            carry_d = ch_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               co_d    = ch_cout;
               ovf_d   = ch_cout ^ ch_cmsb;
            end
         end
         default: begin
            // IDLE and DONE both accept a new request.
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               // Subtraction is a + ~b + 1: the +1 rides in on the carry.
               carry_d = sub | ci;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   // Operand and carry registers are always reloaded before use.
   always_ff @(posedge clk) begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_chunk_adder
// Directed bench for serial_chunk_adder. Three instances (CHUNK = 4, 1, 16)
// share the stimulus; results are compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_serial_chunk_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic        ci = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;

   logic        busy4, done4, co4, ovf4;
   logic [15:0] sum4;
   logic        busy1, done1, co1, ovf1;
   logic [15:0] sum1;
   logic        busy16, done16, co16, ovf16;
   logic [15:0] sum16;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .ci(ci), .a(a), .b(b),
      .busy(busy4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4));

   serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .ci(ci), .a(a), .b(b),
      .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1));

   serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .ci(ci), .a(a), .b(b),
      .busy(busy16), .done(done16), .sum(sum16), .co(co16), .ovf(ovf16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One operation on all three instances. k counts negedges after the
   // accepting edge; done is expected at k = N. With poke set, a start with
   // different operands is pulsed at k=1 and must not disturb the CHUNK=4 run.
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tci, input bit poke,
                        input logic [15:0] es, input logic eco, input logic eovf);
      int l4 = -1, l1 = -1, l16 = -1, nbusy = 0;
      logic [15:0] s4 = '0, s1 = '0, s16 = '0;
      logic c4 = 1'b0, c1 = 1'b0, c16 = 1'b0, v4 = 1'b0, v1 = 1'b0, v16 = 1'b0;
      @(negedge clk);
      a = ta; b = tb_v; sub = ts; ci = tci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy4) nbusy++;
         if (done4 && l4 < 0)   begin l4 = k;  s4 = sum4;   c4 = co4;   v4 = ovf4;  end
         if (done1 && l1 < 0)   begin l1 = k;  s1 = sum1;   c1 = co1;   v1 = ovf1;  end
         if (done16 && l16 < 0) begin l16 = k; s16 = sum16; c16 = co16; v16 = ovf16; end
         if (poke && k == 1) begin
            a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk({tag, ".lat4"}, 32'(l4), 32'd4);
      chk({tag, ".busy4"}, 32'(nbusy), 32'd4);
      chk({tag, ".sum4"}, 32'(s4), 32'(es));
      chk({tag, ".co4"}, 32'(c4), 32'(eco));
      chk({tag, ".ovf4"}, 32'(v4), 32'(eovf));
      chk({tag, ".lat1"}, 32'(l1), 32'd16);
      chk({tag, ".sum1"}, 32'(s1), 32'(es));
      chk({tag, ".co1"}, 32'(c1), 32'(eco));
      chk({tag, ".ovf1"}, 32'(v1), 32'(eovf));
      chk({tag, ".lat16"}, 32'(l16), 32'd1);
      chk({tag, ".sum16"}, 32'(s16), 32'(es));
      chk({tag, ".co16"}, 32'(c16), 32'(eco));
      chk({tag, ".ovf16"}, 32'(v16), 32'(eovf));
   endtask

   initial begin
      int c_first, c_second, ndone;
      logic [15:0] s_first;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy4), 32'd0);
      chk("rst.done", 32'(done4), 32'd0);
      chk("rst.sum", 32'(sum4), 32'd0);
      chk("rst.co", 32'(co4), 32'd0);
      chk("rst.ovf", 32'(ovf4), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.idle_busy", 32'(busy4), 32'd0);

      do_op("add_ci", 16'h1234, 16'h0FFF, 1'b0, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      do_op("add_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Abort mid-run: co/ovf are still 1 from the previous op and the first
      // chunk (4) has already entered the top of sum.
      @(negedge clk);
      a = 16'h1234; b = 16'h0FFF; sub = 1'b0; ci = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort.busy_before", 32'(busy4), 32'd1);
      chk("abort.sum_before", 32'(sum4), 32'h4000);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy4), 32'd0);
      chk("abort.done", 32'(done4), 32'd0);
      chk("abort.sum", 32'(sum4), 32'd0);
      chk("abort.co", 32'(co4), 32'd0);
      chk("abort.ovf", 32'(ovf4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done4 || done1 || done16) ndone++;
      end
      chk("abort.no_done", 32'(ndone), 32'd0);

      do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_ovf", 16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("poke", 16'h1234, 16'h0FFF, 1'b0, 1'b1, 1'b1, 16'h2234, 1'b0, 1'b0);

      // Back-to-back: start held high in the DONE cycle.
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; sub = 1'b0; ci = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c_first = -1;
      for (int k = 0; k < 20 && c_first < 0; k++) begin
         if (done4) c_first = cyc; else @(negedge clk);
      end
      s_first = sum4;
      chk("b2b.first_seen", 32'(c_first >= 0), 32'd1);
      chk("b2b.sum_first", 32'(s_first), 32'h0003);
      a = 16'h00FF; b = 16'h0F01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c_second = -1;
      for (int k = 0; k < 20 && c_second < 0; k++) begin
         if (done4) c_second = cyc; else @(negedge clk);
      end
      chk("b2b.gap", 32'(c_second - c_first), 32'd5);
      chk("b2b.sum_second", 32'(sum4), 32'h1000);
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
